// File: rtl/frame_align_pkg.sv
// Shared state encoding and default constants for the frame-clock aligner.
package frame_align_pkg;
   localparam int unsigned DEF_S             = 8;
   localparam logic [7:0]  DEF_FRAME_PATTERN = 8'hF0;
   localparam int unsigned DEF_SETTLE_CYCLES = 16;
   localparam int unsigned DEF_LOCK_COUNT    = 8;
   localparam int unsigned DEF_LOSS_COUNT    = 4;
   localparam int unsigned CNT_W             = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_SLIP   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAIL   = 3'd5
   } state_t;
endpackage

// File: rtl/frame_align_timer.sv
// Settle countdown: load sets the count, tick decrements it toward zero.
module frame_align_timer
   import frame_align_pkg::*;
#(
   parameter int unsigned LOAD_VAL = DEF_SETTLE_CYCLES
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_tick,
   output logic o_done_c
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CNT_W'(LOAD_VAL);
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   // High on the tick that takes the count to zero, so SETTLE lasts LOAD_VAL cycles.
   assign o_done_c = (r_count <= CNT_W'(1));

endmodule

// File: rtl/frame_align_ctrl.sv
// Frame-clock alignment controller: issues bitslips until the deserialized
// frame word matches the expected pattern, then holds and monitors lock.
module frame_align_ctrl
   import frame_align_pkg::*;
#(
   parameter int unsigned   S             = DEF_S,
   parameter logic [S-1:0]  FRAME_PATTERN = S'(DEF_FRAME_PATTERN),
   parameter int unsigned   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned   LOCK_COUNT    = DEF_LOCK_COUNT,
   parameter int unsigned   LOSS_COUNT    = DEF_LOSS_COUNT
) (
   input  logic              sample_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              restart,
   input  logic [S-1:0]      frame_word,
   output logic              bitslip,
   output logic              locked,
   output logic              error,
   output logic [$clog2(S):0] slip_count,
   output logic [2:0]        state_dbg
);

   localparam int unsigned SCW = $clog2(S) + 1;

   state_t           r_state;
   logic             r_bitslip;
   logic             r_locked;
   logic             r_error;
   logic [SCW-1:0]   r_slip_cnt;
   logic [CNT_W-1:0] r_match_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   logic w_match;
   logic w_restart;
   logic w_lock_hit;
   logic w_loss_hit;
   logic w_timer_clr;
   logic w_timer_load;
   logic w_timer_tick;
   logic w_settle_done;

   assign w_match     = (frame_word == FRAME_PATTERN);
   assign w_restart   = restart && (r_state != ST_IDLE);
   assign w_lock_hit  = w_match && (r_match_cnt == CNT_W'(LOCK_COUNT - 1));
   assign w_loss_hit  = !w_match && (r_miss_cnt == CNT_W'(LOSS_COUNT - 1));
   assign w_timer_clr = reset || !enable;

   // Timer reload on every entry into SETTLE, tick while in it.
   always_comb begin
      w_timer_load = 1'b0;
      w_timer_tick = 1'b0;
      if (w_restart) begin
         w_timer_load = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE:   w_timer_load = 1'b1;
            ST_SETTLE: w_timer_tick = 1'b1;
            ST_SLIP:   w_timer_load = 1'b1;
            ST_LOCKED: w_timer_load = w_loss_hit;
            default:   w_timer_load = 1'b0;
         endcase
      end
   end

   frame_align_timer #(
      .LOAD_VAL (SETTLE_CYCLES)
   ) u_timer (
      .i_clk    (sample_clk),
      .i_clr    (w_timer_clr),
      .i_load   (w_timer_load),
      .i_tick   (w_timer_tick),
      .o_done_c (w_settle_done)
   );

   always_ff @(posedge sample_clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bitslip   <= 1'b0;
         r_locked    <= 1'b0;
         r_error     <= 1'b0;
         r_slip_cnt  <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_bitslip <= 1'b0;
         if (!enable) begin
            r_state     <= ST_IDLE;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_slip_cnt  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
         end else if (w_restart) begin
            r_state     <= ST_SETTLE;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_slip_cnt  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state    <= ST_SETTLE;
                  r_slip_cnt <= '0;
               end
               ST_SETTLE: begin
                  if (w_settle_done) begin
                     r_state     <= ST_CHECK;
                     r_match_cnt <= '0;
                  end
               end
               ST_CHECK: begin
                  if (w_match) begin
                     r_match_cnt <= r_match_cnt + CNT_W'(1);
                     if (w_lock_hit) begin
                        r_state    <= ST_LOCKED;
                        r_locked   <= 1'b1;
                        r_miss_cnt <= '0;
                     end
                  end else if (r_slip_cnt < SCW'(S)) begin
                     r_state <= ST_SLIP;
                  end else begin
                     r_state <= ST_FAIL;
                     r_error <= 1'b1;
                  end
               end
               ST_SLIP: begin
                  r_bitslip <= 1'b1;
                  r_state   <= ST_SETTLE;
                  if (r_slip_cnt < SCW'(S)) begin
                     r_slip_cnt <= r_slip_cnt + SCW'(1);
                  end
               end
               ST_LOCKED: begin
                  if (w_match) begin
                     r_miss_cnt <= '0;
                  end else if (w_loss_hit) begin
                     r_state    <= ST_SETTLE;
                     r_locked   <= 1'b0;
                     r_slip_cnt <= '0;
                     r_miss_cnt <= '0;
                  end else begin
                     r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                  end
               end
               ST_FAIL: begin
                  r_error <= 1'b1;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bitslip    = r_bitslip;
   assign locked     = r_locked;
   assign error      = r_error;
   assign slip_count = r_slip_cnt;
   assign state_dbg  = r_state;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Directed bench for frame_align_ctrl with a rotating-deserializer model.
module tb_frame_align_ctrl;

   logic       sample_clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       restart;
   logic [7:0] frame_word;
   logic       bitslip;
   logic       locked;
   logic       error;
   logic [3:0] slip_count;
   logic [2:0] state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mdl_base = 8'h00;
   logic       mdl_load = 1'b0;
   logic       mdl_en   = 1'b1;
   logic [7:0] inj_word = 8'h00;
   logic [7:0] mdl_word = 8'h00;
   logic       bs_d1 = 1'b0;
   logic       bs_d2 = 1'b0;
   int         cyc = 0;
   int         n_pulse = 0;
   int         pulse_cyc [64];

   always #5 sample_clk = ~sample_clk;

   assign frame_word = mdl_en ? mdl_word : inj_word;

   frame_align_ctrl dut (
      .sample_clk (sample_clk),
      .reset      (reset),
      .enable     (enable),
      .restart    (restart),
      .frame_word (frame_word),
      .bitslip    (bitslip),
      .locked     (locked),
      .error      (error),
      .slip_count (slip_count),
      .state_dbg  (state_dbg)
   );

   // Deserializer: word rotates left by one a couple of cycles after a bitslip pulse.
   always @(posedge sample_clk) begin
      cyc <= cyc + 1;
      if (bitslip) begin
         if (n_pulse < 64) pulse_cyc[n_pulse] <= cyc;
         n_pulse <= n_pulse + 1;
      end
      if (mdl_load) begin
         mdl_word <= mdl_base;
         bs_d1    <= 1'b0;
         bs_d2    <= 1'b0;
      end else begin
         bs_d1 <= bitslip;
         bs_d2 <= bs_d1;
         if (bs_d2) mdl_word <= {mdl_word[6:0], mdl_word[7]};
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_word(input logic [7:0] w);
      @(negedge sample_clk);
      mdl_base = w;
      mdl_load = 1'b1;
      @(negedge sample_clk);
      mdl_load = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
      int n = 0;
      while (state_dbg !== st && n < budget) begin
         @(negedge sample_clk);
         n++;
      end
      check_val(tag, state_dbg, st);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_state"}, state_dbg, 3'd0);
      check_val({tag, "_bitslip"}, bitslip, 1'b0);
      check_val({tag, "_locked"}, locked, 1'b0);
      check_val({tag, "_error"}, error, 1'b0);
      check_val({tag, "_slip"}, slip_count, 4'd0);
   endtask

   initial begin
      int n;
      int p0;
      reset   = 1'b1;
      enable  = 1'b0;
      restart = 1'b0;
      repeat (3) @(negedge sample_clk);
      check_all_zero("reset");

      // Already aligned: lock after SETTLE+LOCK+1 cycles, no slips.
      reset = 1'b0;
      set_word(8'hF0);
      p0 = n_pulse;
      enable = 1'b1;
      n = 0;
      while (!locked && n < 100) begin
         @(posedge sample_clk);
         #1;
         n++;
      end
      check_val("aligned_lat", n, 25);
      check_val("aligned_pulses", n_pulse - p0, 0);
      check_val("aligned_state", state_dbg, 3'd4);
      check_val("aligned_slip", slip_count, 4'd0);

      // Loss of lock: 3 misses tolerated, 4 drop lock.
      @(negedge sample_clk);
      inj_word = 8'hF0;
      mdl_en   = 1'b0;
      inj_word = 8'h00;
      repeat (3) @(negedge sample_clk);
      check_val("miss3_locked", locked, 1'b1);
      inj_word = 8'hF0;
      @(negedge sample_clk);
      check_val("miss_clr_locked", locked, 1'b1);
      inj_word = 8'h00;
      repeat (3) @(negedge sample_clk);
      check_val("miss3b_locked", locked, 1'b1);
      @(negedge sample_clk);
      check_val("loss_locked", locked, 1'b0);
      check_val("loss_state", state_dbg, 3'd1);
      check_val("loss_slip", slip_count, 4'd0);
      enable = 1'b0;
      mdl_en = 1'b1;
      @(negedge sample_clk);
      check_val("disable_idle", state_dbg, 3'd0);

      // Rotation of 3: three pulses, SETTLE+2 apart, then lock.
      set_word(8'h1E);
      p0 = n_pulse;
      enable = 1'b1;
      n = 0;
      while (!locked && n < 500) begin
         @(negedge sample_clk);
         n++;
      end
      check_val("rot3_locked", locked, 1'b1);
      check_val("rot3_pulses", n_pulse - p0, 3);
      check_val("rot3_gap1", pulse_cyc[p0+1] - pulse_cyc[p0], 18);
      check_val("rot3_gap2", pulse_cyc[p0+2] - pulse_cyc[p0+1], 18);
      check_val("rot3_slip", slip_count, 4'd3);
      enable = 1'b0;
      @(negedge sample_clk);

      // Unalignable word: S slips then FAIL; restart recovers.
      set_word(8'hAA);
      p0 = n_pulse;
      enable = 1'b1;
      wait_state("aa_fail_state", 3'd5, 1000);
      check_val("aa_pulses", n_pulse - p0, 8);
      check_val("aa_error", error, 1'b1);
      check_val("aa_locked", locked, 1'b0);
      check_val("aa_slip", slip_count, 4'd8);
      repeat (4) @(negedge sample_clk);
      check_val("aa_hold", state_dbg, 3'd5);
      restart = 1'b1;
      @(negedge sample_clk);
      restart = 1'b0;
      check_val("restart_error", error, 1'b0);
      check_val("restart_slip", slip_count, 4'd0);
      check_val("restart_state", state_dbg, 3'd1);

      // enable=0 while in SLIP: no pulse, IDLE.
      wait_state("reach_slip", 3'd3, 200);
      p0 = n_pulse;
      enable = 1'b0;
      @(negedge sample_clk);
      check_all_zero("slip_dis");
      repeat (5) @(negedge sample_clk);
      check_val("slip_dis_pulses", n_pulse - p0, 0);

      // reset during CHECK.
      enable = 1'b1;
      wait_state("reach_check", 3'd2, 200);
      reset = 1'b1;
      @(negedge sample_clk);
      check_all_zero("chk_rst");
      enable = 1'b0;
      reset  = 1'b0;
      @(negedge sample_clk);

      // restart together with enable=0, then with reset.
      enable = 1'b1;
      repeat (3) @(negedge sample_clk);
      check_val("pre_rs_state", state_dbg, 3'd1);
      restart = 1'b1;
      enable  = 1'b0;
      @(negedge sample_clk);
      restart = 1'b0;
      check_val("rs_dis_state", state_dbg, 3'd0);
      enable = 1'b1;
      repeat (3) @(negedge sample_clk);
      restart = 1'b1;
      reset   = 1'b1;
      @(negedge sample_clk);
      restart = 1'b0;
      check_all_zero("rs_rst");
      reset  = 1'b0;
      enable = 1'b0;
      @(negedge sample_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_align_ctrl.md
FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

Interface
REQ-001 SHALL have parameter S, default 8: deserialization factor; width of frame_word.
REQ-002 SHALL have parameter FRAME_PATTERN, default 8'hF0: expected deserialized frame-clock word.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: wait after each bitslip before comparing, range 1..255.
REQ-004 SHALL have parameter LOCK_COUNT, default 8: consecutive matches needed to declare lock, range 1..255.
REQ-005 SHALL have parameter LOSS_COUNT, default 4: consecutive mismatches in LOCKED that drop lock, range 1..255.
REQ-006 SHALL have port sample_clk  in  1  sole clock, the rx_bufg_pll_x1 domain of the deserializer.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  in  1  level; 1 runs alignment, 0 forces IDLE.
REQ-009 SHALL have port restart  in  1  single-cycle pulse; restarts alignment from any non-IDLE state.
REQ-010 SHALL have port frame_word  in  S  deserialized frame lane, one new word per cycle.
REQ-011 SHALL have port bitslip  out  1  one-cycle pulse to the deserializer bitslip input.
REQ-012 SHALL have port locked  out  1  alignment achieved and held.
REQ-013 SHALL have port error  out  1  no slip position matched.
REQ-014 SHALL have port slip_count  out  $clog2(S)+1  bitslips issued in current attempt.
REQ-015 SHALL have port state_dbg  out  3  current state encoding.

Function
REQ-016 SHALL implement states IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL, all outputs registered.
REQ-017 IDLE: on enable=1 SHALL go to SETTLE, clear slip_count, load settle counter with SETTLE_CYCLES.
REQ-018 SETTLE: SHALL decrement settle counter each cycle; on reaching 0 SHALL go to CHECK with match counter cleared.
REQ-019 CHECK: frame_word==FRAME_PATTERN SHALL increment match counter; the LOCK_COUNT-th consecutive match SHALL enter LOCKED with locked=1 on the same edge.
REQ-020 CHECK: any mismatch SHALL go to SLIP if slip_count<S, else to FAIL.
REQ-021 SLIP: bitslip SHALL be 1 for exactly one cycle, slip_count incremented by 1 on the same edge, then SETTLE with counter reloaded; bitslip SHALL be 0 in all other states.
REQ-022 LOCKED: mismatch SHALL increment miss counter, match SHALL clear it; LOSS_COUNT-th consecutive mismatch SHALL clear locked, clear slip_count, enter SETTLE.
REQ-023 FAIL: error SHALL be 1; state held until restart or enable=0.
REQ-024 restart=1 (enable=1) in any non-IDLE state SHALL enter SETTLE, clearing slip_count, error, locked, counters.
REQ-025 enable=0 SHALL override restart and all transitions: next state IDLE, locked=0, error=0, bitslip=0.
REQ-026 slip_count SHALL saturate at S; never wraps.

Reset
REQ-027 reset=1 at a sample_clk edge SHALL set state IDLE, bitslip=0, locked=0, error=0, slip_count=0, all internal counters 0, overriding enable and restart, including mid-SLIP.

Structure
REQ-028 State encoding and default parameter constants SHALL live in shared package frame_align_pkg.
REQ-029 Settle countdown SHALL be a sub-module frame_align_timer (load, tick, done).

Verification (bench models deserializer: rotates word left by 1 position SETTLE-independent, 2 cycles after bitslip)
REQ-030 Word already 8'hF0, enable rises -> 0 bitslip pulses, locked=1 exactly SETTLE_CYCLES+LOCK_COUNT+1 cycles after enable.
REQ-031 Word initially 8'h1E (rotation 3 from F0) -> exactly 3 bitslip pulses each SETTLE_CYCLES+2 cycles apart, slip_count=3, locked=1.
REQ-032 Word constant 8'hAA -> 8 bitslip pulses, then error=1, locked=0, slip_count=8; restart pulse -> error=0, slip_count=0, state SETTLE.
REQ-033 Locked, inject 3 mismatching words then 8'hF0 -> locked stays 1; inject 4 consecutive -> locked=0 next edge, state SETTLE.
REQ-034 enable=0 during SLIP cycle, and separately reset=1 during CHECK -> next edge IDLE, all outputs 0, no further bitslip.
REQ-035 restart and enable=0 in same cycle -> IDLE; restart and reset same cycle -> IDLE with all outputs 0.
